i2s_rx_axis: RTL and testbench

- Upstream source stage for the stereo IIR filter wrapper.
- Oversamples an external I2S serial audio bus (BCLK/LRCLK/SDATA) in the aclk domain and extracts 16-bit left and right samples.
- Packs each pair into one 32-bit AXI4-Stream beat: [31:16] = Left, [15:0] = Right, which is the same format the filter's s_axis port consumes.
- Buffers beats in a small FIFO and reports overflow.

---
 rtl/i2s_rx_axis_if.sv | 12 +
 rtl/i2s_rx_axis.sv | 184 ++++++++++++++++++
 tb/tb_i2s_rx_axis.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_axis_if.sv
// AXI4-Stream bundle carrying packed {left, right} sample pairs.
interface i2s_rx_axis_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/i2s_rx_axis.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA, packs 16-bit {L, R} pairs into a stream FIFO.
// Define I2S_RX_LJ_MODE_EN for left-justified framing (LRCLK high = left, MSB on the change edge).
//   state     | meaning
//   SYNC_WAIT | not framed; waiting for the LRCLK change into a left slot
//   CAP_L     | capturing the left word
//   CAP_R     | capturing the right word; frame pushed on its 16th bit or at slot end
module i2s_rx_axis #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PACKET_LEN = 0
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          enable,
  input  logic          clear_ovf,
  input  logic          i2s_bclk,
  input  logic          i2s_lrclk,
  input  logic          i2s_sdata,
  i2s_rx_axis_if.master m_axis,
  output logic          overflow,
  output logic          locked
);
  typedef enum logic [1:0] {SYNC_WAIT = 2'd0, CAP_L = 2'd1, CAP_R = 2'd2} state_t;

`ifdef I2S_RX_LJ_MODE_EN
  localparam logic LEFT_LVL = 1'b1;
  localparam logic LJ_MODE  = 1'b1;
`else
  localparam logic LEFT_LVL = 1'b0;
  localparam logic LJ_MODE  = 1'b0;
`endif
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PACKET_LEN);

  state_t              state_q, state_d;
  logic [2:0]          bclk_sync_q, bclk_sync_d;
  logic [1:0]          lr_sync_q, lr_sync_d, sd_sync_q, sd_sync_d;
  logic                lr_valid_q, lr_valid_d, lr_prev_q, lr_prev_d;
  logic [15:0]         sh_q, sh_d, left_q, left_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH:0] mem_d [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d, cnt_next;
  logic                overflow_q, overflow_d;

  logic                lr_s, sd_s, bit_edge, lr_change;
  logic                latch_l, push_full, push_short, push_req;
  logic                empty, full, pop, accept, drop, push_last;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH:0]   rd_entry;

  assign lr_s     = lr_sync_q[1];
  assign sd_s     = sd_sync_q[1];
  assign bit_edge = bclk_sync_q[1] & ~bclk_sync_q[2];

  always_comb begin
    bclk_sync_d = {bclk_sync_q[1:0], i2s_bclk};
    lr_sync_d   = {lr_sync_q[0], i2s_lrclk};
    sd_sync_d   = {sd_sync_q[0], i2s_sdata};
    lr_valid_d  = lr_valid_q;
    lr_prev_d   = lr_prev_q;
    lr_change   = 1'b0;
    if (!enable) begin
      lr_valid_d = 1'b0;
    end else if (bit_edge) begin
      // the first edge after reset/enable only seeds lr_prev
      lr_valid_d = 1'b1;
      lr_prev_d  = lr_s;
      lr_change  = lr_valid_q && (lr_s != lr_prev_q);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= SYNC_WAIT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = SYNC_WAIT;
    end else if (lr_change) begin
      case (state_q)
        SYNC_WAIT: if (lr_s == LEFT_LVL) state_d = CAP_L;
        CAP_L:     state_d = CAP_R;
        CAP_R:     state_d = CAP_L;
        default:   state_d = SYNC_WAIT;
      endcase
    end
  end

  always_comb begin
    locked     = (state_q != SYNC_WAIT);
    latch_l    = enable && lr_change && (state_q == CAP_L);
    push_full  = enable && bit_edge && !lr_change && (state_q == CAP_R) && (bit_cnt_q == 5'd15);
    push_short = enable && lr_change && (state_q == CAP_R) && (bit_cnt_q != 5'd16);
    push_req   = push_full | push_short;
  end

  // Bits land at 15-bit_cnt, so a short slot is left-aligned with zero LSBs for free.
  always_comb begin
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    if (!enable) begin
      sh_d      = '0;
      bit_cnt_d = '0;
    end else if (bit_edge) begin
      if (lr_change) begin
        sh_d      = '0;
        bit_cnt_d = '0;
        if (LJ_MODE) begin
          sh_d[15]  = sd_s;
          bit_cnt_d = 5'd1;
        end
      end else if (!bit_cnt_q[4]) begin
        sh_d[4'd15 - bit_cnt_q[3:0]] = sd_s;
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end
    left_d    = latch_l ? sh_q : left_q;
    push_data = {left_q, push_full ? sh_d : sh_q};
  end

  always_comb begin
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop       = !empty && m_axis.tready;
    accept    = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    cnt_next  = beat_cnt_q + CNT_W'(1);
    push_last = (PACKET_LEN != 0) && (cnt_next == PKT_LAST);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    if (accept) begin
      mem_d[wr_ptr_q[AW-1:0]] = {push_last, push_data};
      wr_ptr_d   = wr_ptr_q + 1'b1;
      beat_cnt_d = push_last ? '0 : cnt_next;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    overflow_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
    rd_entry   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bclk_sync_q <= '0;
      lr_sync_q   <= '0;
      sd_sync_q   <= '0;
      lr_valid_q  <= 1'b0;
      lr_prev_q   <= 1'b0;
      sh_q        <= '0;
      left_q      <= '0;
      bit_cnt_q   <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lr_sync_q   <= lr_sync_d;
      sd_sync_q   <= sd_sync_d;
      lr_valid_q  <= lr_valid_d;
      lr_prev_q   <= lr_prev_d;
      sh_q        <= sh_d;
      left_q      <= left_d;
      bit_cnt_q   <= bit_cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = rd_entry[DATA_WIDTH-1:0];
  assign m_axis.tlast  = rd_entry[DATA_WIDTH];
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_i2s_rx_axis.sv
// Randomised I2S stimulus against a frame-level model: expected beats are the frames the bench sends.
module tb_i2s_rx_axis;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int PLEN  = 4;
`ifdef I2S_RX_LJ_MODE_EN
  localparam bit LEFT_LVL = 1'b1;
  localparam int OFF      = 0;
`else
  localparam bit LEFT_LVL = 1'b0;
  localparam int OFF      = 1;
`endif

  logic aclk = 0, aresetn = 0, enable = 0, clear_ovf = 0;
  logic i2s_bclk = 0, i2s_lrclk = 0, i2s_sdata = 0;
  logic overflow, locked;

  i2s_rx_axis_if #(.DATA_WIDTH(DW)) axis ();

  i2s_rx_axis #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PACKET_LEN(PLEN)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .clear_ovf(clear_ovf),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .m_axis(axis), .overflow(overflow), .locked(locked));

  always #5 aclk = ~aclk;

  int tests = 0, fails = 0;
  logic [32:0] exp_q[$];
  bit ovf_m = 0;
  int cnt_m = 0;
  bit prev_valid = 0, prev_lr = 0, left_armed = 0, right_armed = 0, pend = 0;
  logic [31:0] pend_data;
  logic [15:0] lw;
  int rdy_mode = 1;
  int beats = 0;
  logic [31:0] last_data = '0;
  logic [7:0] tl_hist = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endfunction

  task automatic model_accept(input logic [31:0] data);
    if (exp_q.size() >= DEPTH) ovf_m = 1;
    else begin
      cnt_m++;
      exp_q.push_back({(cnt_m % PLEN) == 0, data});
    end
  endtask

  task automatic model_unlock();
    prev_valid = 0; left_armed = 0; right_armed = 0; pend = 0;
  endtask

  task automatic send_bit(input bit lr, input bit d);
    i2s_bclk = 0; i2s_lrclk = lr; i2s_sdata = d;
    #40; i2s_bclk = 1; #40;
  endtask

  // One slot of nbk BCLKs carrying word w; frame bookkeeping is done before each bit is driven.
  task automatic send_slot(input bit lr, input logic [15:0] w, input int nbk, input bit is_right);
    bit change, d;
    int idx, cap;
    logic [15:0] wm;
    cap = nbk - OFF;
    if (cap > 16) cap = 16;
    wm = w & ~(16'hFFFF >> cap);
    for (int k = 0; k < nbk; k++) begin
      idx = k - OFF;
      d = (idx >= 0 && idx < 16) ? wm[15-idx] : 1'($urandom);
      if (k == 0) begin
        change = prev_valid && (lr != prev_lr);
        if (change && pend) begin model_accept(pend_data); pend = 0; end
        if (is_right) right_armed = change && left_armed;
        else begin left_armed = change && (lr == LEFT_LVL); lw = wm; end
        prev_valid = 1; prev_lr = lr;
      end
      if (is_right && right_armed && idx == 15) model_accept({lw, wm});
      send_bit(lr, d);
    end
    if (is_right && right_armed && cap < 16) begin pend = 1; pend_data = {lw, wm}; end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nbk);
    send_slot(LEFT_LVL, l, nbk, 0);
    send_slot(!LEFT_LVL, r, nbk, 1);
  endtask

  task automatic do_reset();
    i2s_bclk = 0; aresetn = 0;
    exp_q.delete(); ovf_m = 0; cnt_m = 0; model_unlock();
    #100; aresetn = 1; #20;
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge aclk);
      done = (exp_q.size() == 0) && !axis.tvalid;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin : ready_drv
    axis.tready = 1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        0: axis.tready = 0;
        1: axis.tready = 1;
        default: axis.tready = 1'($urandom);
      endcase
    end
  end

  initial begin : compare
    bit prev_stall = 0;
    logic [31:0] held_data = '0;
    logic held_last = 0;
    logic [32:0] e;
    forever begin
      @(negedge aclk);
      if (!aresetn) prev_stall = 0;
      else begin
        if (prev_stall) begin
          check("stall_tdata", axis.tdata, held_data);
          check("stall_tlast", 32'(axis.tlast), 32'(held_last));
        end
        if (axis.tvalid && axis.tready) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_beat: actual=%h required=none", axis.tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_tdata", axis.tdata, e[31:0]);
            check("beat_tlast", 32'(axis.tlast), 32'(e[32]));
          end
          beats++; last_data = axis.tdata; tl_hist = {tl_hist[6:0], axis.tlast};
        end
        prev_stall = axis.tvalid && !axis.tready;
        held_data = axis.tdata; held_last = axis.tlast;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int saved;
    int lens[5] = '{32, 24, 17, 12, 20};
    #100; aresetn = 1; #20;
    check("rst_tvalid", 32'(axis.tvalid), 32'd0);
    check("rst_tlast", 32'(axis.tlast), 32'd0);
    check("rst_tdata", axis.tdata, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);

    // 1: basic pair, 64fs
    enable = 1; rdy_mode = 1;
    send_slot(!LEFT_LVL, 16'h0, 32, 1);
    send_frame(16'd10000, 16'hEC78, 32);
    wait_drain("t1_drain");
    check("t1_tdata", last_data, 32'h2710EC78);
    check("t1_tlast", 32'(tl_hist[0]), 32'd0);
    check("t1_locked", 32'(locked), 32'd1);

    // 2: start mid-left slot after re-enable
    enable = 0; model_unlock(); repeat (4) @(negedge aclk);
    enable = 1; saved = beats;
    send_slot(LEFT_LVL, 16'hBEEF, 12, 0);
    send_slot(!LEFT_LVL, 16'hCAFE, 32, 1);
    send_frame(16'h1357, 16'h2468, 32);
    wait_drain("t2_drain");
    check("t2_beats", beats - saved, 32'd1);
    check("t2_tdata", last_data, 32'h13572468);

    // 3: overflow with a stalled sink
    rdy_mode = 0; saved = beats;
    for (int i = 1; i <= 6; i++) send_frame(16'(i), 16'(-i), 32);
    repeat (10) @(negedge aclk);
    check("t3_ovf_set", 32'(overflow), 32'd1);
    check("t3_ovf_model", 32'(overflow), 32'(ovf_m));
    rdy_mode = 1;
    wait_drain("t3_drain");
    check("t3_beats", beats - saved, 32'd4);
    check("t3_last", last_data, 32'h0004FFFC);
    clear_ovf = 1; @(negedge aclk); clear_ovf = 0; ovf_m = 0; @(negedge aclk);
    check("t3_ovf_clr", 32'(overflow), 32'd0);

    // 4: packet boundaries every 4 beats
    do_reset(); enable = 1; rdy_mode = 2;
    send_slot(!LEFT_LVL, 16'h0, 32, 1);
    for (int i = 0; i < 8; i++) send_frame(16'($urandom), 16'($urandom), 32);
    wait_drain("t4_drain");
    check("t4_tlast_pattern", 32'(tl_hist), 32'h11);

    // 5: short slots (change edge plus 8 data bits)
    rdy_mode = 1;
    send_frame(16'hA500, 16'h5A00, 8 + OFF);
    send_slot(LEFT_LVL, 16'h7777, 32, 0);
    wait_drain("t5_drain");
    check("t5_tdata", last_data, 32'hA5005A00);

    // 6a: enable dropped during the right slot
    saved = beats;
    send_slot(!LEFT_LVL, 16'h9999, 8, 1);
    enable = 0; model_unlock(); repeat (10) @(negedge aclk);
    check("t6_locked", 32'(locked), 32'd0);
    check("t6_no_beat", beats - saved, 32'd0);
    enable = 1;
    send_slot(!LEFT_LVL, 16'h0, 32, 1);
    send_frame(16'h1111, 16'h2222, 32);
    wait_drain("t6_drain");
    check("t6_beats", beats - saved, 32'd1);
    check("t6_tdata", last_data, 32'h11112222);

    // 6b: reset mid-frame
    saved = beats;
    send_slot(LEFT_LVL, 16'h5555, 32, 0);
    send_slot(!LEFT_LVL, 16'h6666, 10, 1);
    do_reset();
    check("t6r_locked", 32'(locked), 32'd0);
    send_slot(!LEFT_LVL, 16'h0, 32, 1);
    send_frame(16'h3333, 16'h4444, 32);
    wait_drain("t6r_drain");
    check("t6r_beats", beats - saved, 32'd1);
    check("t6r_tdata", last_data, 32'h33334444);

    // random frames, mixed slot lengths and sink backpressure
    rdy_mode = 2;
    for (int i = 0; i < 12; i++)
      send_frame(16'($urandom), 16'($urandom), lens[$urandom_range(4)]);
    send_slot(LEFT_LVL, 16'($urandom), 20, 0);
    rdy_mode = 1;
    wait_drain("rand_drain");
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
    check("final_overflow", 32'(overflow), 32'(ovf_m));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
